usb_ctrl_out_pe: RTL



---
 rtl/usb_consts_pkg.sv | 43 ++++
 rtl/usb_ctrl_out_pe_if.sv | 21 ++
 rtl/usb_timeout_ctr.sv | 39 +++
 rtl/usb_ctrl_out_pe.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/usb_consts_pkg.sv
// USB protocol constants shared by the EP0 engines: 4-bit PIDs, PID type
// encodings, and the OUT protocol engine's state and end-of-packet outcome types.
package usb_consts_pkg;

  localparam logic [3:0] UsbPidOut   = 4'b0001;
  localparam logic [3:0] UsbPidSetup = 4'b1101;
  localparam logic [3:0] UsbPidData0 = 4'b0011;
  localparam logic [3:0] UsbPidData1 = 4'b1011;
  localparam logic [3:0] UsbPidAck   = 4'b0010;
  localparam logic [3:0] UsbPidNak   = 4'b1010;
  localparam logic [3:0] UsbPidStall = 4'b1110;

  // PID[1:0] selects the packet class.
  typedef enum logic [1:0] {
    PidTypeSpecial   = 2'b00,
    PidTypeToken     = 2'b01,
    PidTypeHandshake = 2'b10,
    PidTypeData      = 2'b11
  } pid_type_e;

  typedef enum logic [2:0] {
    StIdle,
    StRcvdToken,
    StRcvdData,
    StSendHs,
    StWaitTx
  } pe_state_e;

  typedef struct packed {
    pe_state_e  next_state;
    logic       acked;
    logic       rollback;
    logic       send_hs;
    logic [3:0] hs_pid;
    logic       toggle;
  } pe_outcome_t;

  // DATA0 and DATA1 only; DATA2/MDATA are not valid on a full-speed control pipe.
  function automatic logic is_data01(input logic [3:0] pid);
    return (pid_type_e'(pid[1:0]) == PidTypeData) && !pid[2];
  endfunction

endpackage

// File: rtl/usb_ctrl_out_pe_if.sv
// Decoded receive stream from the rx decoder: token and data packets, already
// PID- and CRC-checked. The decoder drives it (master), the protocol engine consumes it (slave).
interface usb_ctrl_out_pe_if;
  logic       token_valid;
  logic [3:0] pid;
  logic [6:0] addr;
  logic [3:0] endp;
  logic       data_start;
  logic       data_put;
  logic [7:0] data;
  logic       pkt_end;
  logic       pkt_ok;

  modport master (
    output token_valid, pid, addr, endp, data_start, data_put, data, pkt_end, pkt_ok
  );

  modport slave (
    input token_valid, pid, addr, endp, data_start, data_put, data, pkt_end, pkt_ok
  );
endinterface

// File: rtl/usb_timeout_ctr.sv
// Saturating cycle counter. It counts while enabled and expire_o is raised once
// it has counted Cycles-1. clr_i wins over en_i.
module usb_timeout_ctr #(
  parameter int unsigned Cycles = 1000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CntW = (Cycles > 1) ? $clog2(Cycles) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Cycles - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expire_o = (cnt_q == LastCnt);

  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/usb_ctrl_out_pe.sv
// OUT/SETUP protocol engine for the control endpoint. It matches tokens, streams
// payload bytes into the endpoint, tracks the data toggle, and requests the handshake.
module usb_ctrl_out_pe
  import usb_consts_pkg::*;
#(
  parameter int unsigned MaxPktSizeByte = 32,
  parameter int unsigned PktW           = $clog2(MaxPktSizeByte),
  parameter int unsigned EpNum          = 0,
  parameter int unsigned TimeoutCycles  = 1000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [6:0]          dev_addr_i,
  usb_ctrl_out_pe_if.slave    rx_if,
  output logic                out_ep_data_put_o,
  output logic [PktW-1:0]     out_ep_put_addr_o,
  output logic [7:0]          out_ep_data_o,
  output logic                out_ep_acked_o,
  output logic                out_ep_rollback_o,
  output logic                out_ep_setup_o,
  input  logic                out_ep_full_i,
  input  logic                out_ep_stall_i,
  output logic                tx_pkt_start_o,
  output logic [3:0]          tx_pid_o,
  input  logic                tx_pkt_end_i,
  output logic                out_toggle_o
);

  localparam logic [3:0]  EpId   = 4'(EpNum);
  localparam logic [PktW:0] MaxIdx = (PktW + 1)'(MaxPktSizeByte);

  pe_state_e       state_q;
  logic            put_q, acked_q, rollback_q, setup_q, tx_start_q;
  logic [PktW-1:0] put_addr_q;
  logic [7:0]      data_q;
  logic [3:0]      tx_pid_q;
  logic            toggle_q, pid_toggle_q, overflow_q;
  // One bit wider than the address so the index can reach MaxPktSizeByte and stop there.
  logic [PktW:0]   idx_q;

  logic        tmo_expire;
  logic        token_hit;
  logic        puts_blocked;
  pe_outcome_t outcome_d;

  usb_timeout_ctr #(
    .Cycles (TimeoutCycles)
  ) u_tmo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (state_q != StRcvdToken),
    .en_i     (state_q == StRcvdToken),
    .expire_o (tmo_expire)
  );

  assign token_hit = rx_if.token_valid
                     && (rx_if.pid == UsbPidOut || rx_if.pid == UsbPidSetup)
                     && (rx_if.addr == dev_addr_i) && (rx_if.endp == EpId);

  // A SETUP must always land, so only plain OUT data honours full/stall.
  assign puts_blocked = !setup_q && (out_ep_full_i || out_ep_stall_i);

  always_comb begin
    outcome_d.next_state = StIdle;
    outcome_d.acked      = 1'b0;
    outcome_d.rollback   = 1'b1;
    outcome_d.send_hs    = 1'b0;
    outcome_d.hs_pid     = UsbPidAck;
    outcome_d.toggle     = toggle_q;
    if (rx_if.pkt_ok && !overflow_q && !(setup_q && pid_toggle_q)) begin
      outcome_d.send_hs    = 1'b1;
      outcome_d.next_state = StSendHs;
      if (!setup_q && out_ep_stall_i) begin
        outcome_d.hs_pid = UsbPidStall;
      end else if (!setup_q && out_ep_full_i) begin
        outcome_d.hs_pid = UsbPidNak;
      end else if (pid_toggle_q == toggle_q) begin
        outcome_d.acked    = 1'b1;
        outcome_d.rollback = 1'b0;
        outcome_d.toggle   = ~toggle_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      put_q        <= 1'b0;
      put_addr_q   <= '0;
      data_q       <= '0;
      acked_q      <= 1'b0;
      rollback_q   <= 1'b0;
      setup_q      <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_pid_q     <= UsbPidAck;
      toggle_q     <= 1'b0;
      pid_toggle_q <= 1'b0;
      idx_q        <= '0;
      overflow_q   <= 1'b0;
    end else begin
      put_q      <= 1'b0;
      acked_q    <= 1'b0;
      rollback_q <= 1'b0;
      tx_start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          setup_q <= 1'b0;
          if (token_hit) begin
            state_q    <= StRcvdToken;
            put_addr_q <= '0;
            idx_q      <= '0;
            overflow_q <= 1'b0;
            if (rx_if.pid == UsbPidSetup) begin
              setup_q  <= 1'b1;
              toggle_q <= 1'b0;
            end
          end
        end
        StRcvdToken: begin
          if (rx_if.data_start && is_data01(rx_if.pid)) begin
            state_q      <= StRcvdData;
            pid_toggle_q <= rx_if.pid[3];
          end else if (rx_if.data_start || tmo_expire) begin
            state_q <= StIdle;
            setup_q <= 1'b0;
          end
        end
        StRcvdData: begin
          if (rx_if.data_put) begin
            if (idx_q < MaxIdx) begin
              idx_q <= idx_q + 1'b1;
              if (!puts_blocked) begin
                put_q      <= 1'b1;
                data_q     <= rx_if.data;
                put_addr_q <= idx_q[PktW-1:0];
              end
            end else begin
              overflow_q <= 1'b1;
            end
          end
          if (rx_if.pkt_end) begin
            state_q    <= outcome_d.next_state;
            acked_q    <= outcome_d.acked;
            rollback_q <= outcome_d.rollback;
            tx_start_q <= outcome_d.send_hs;
            toggle_q   <= outcome_d.toggle;
            if (outcome_d.send_hs) begin
              tx_pid_q <= outcome_d.hs_pid;
            end
          end
        end
        StSendHs: begin
          setup_q <= 1'b0;
          state_q <= StWaitTx;
        end
        StWaitTx: begin
          setup_q <= 1'b0;
          if (tx_pkt_end_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_ep_data_put_o = put_q;
  assign out_ep_put_addr_o = put_addr_q;
  assign out_ep_data_o     = data_q;
  assign out_ep_acked_o    = acked_q;
  assign out_ep_rollback_o = rollback_q;
  assign out_ep_setup_o    = setup_q;
  assign tx_pkt_start_o    = tx_start_q;
  assign tx_pid_o          = tx_pid_q;
  assign out_toggle_o      = toggle_q;

endmodule
